// File: rtl/cascade_inta_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cascade_pkg
// Description : Shared types and constants for the 8259 cascade INTA
//               sequencer: FSM state encoding, VEC_SEL byte codes, the CALL
//               opcode and per-CPU pulse counts, plus helpers that decide
//               which vector byte (if any) this device releases on a pulse.
// Revision    : 1.0 - initial release
// ============================================================================
package cascade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] VSEL_CALL = 2'd0;
  localparam logic [1:0] VSEL_LO   = 2'd1;
  localparam logic [1:0] VSEL_HI   = 2'd2;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  localparam logic [1:0] PULSES_8086 = 2'd2;
  localparam logic [1:0] PULSES_8085 = 2'd3;

  // Byte presented on a given pulse: 8085 walks CALL/LO/HI, 8086 only
  // carries a vector on its second pulse.
  function automatic logic [1:0] vsel_for(input logic m8086, input logic [1:0] pulse);
    return m8086 ? VSEL_LO : (pulse - 2'd1);
  endfunction

  // Whether this device owns the data bus on the given pulse. A cascaded
  // master only supplies the CALL; the addressed slave supplies the rest.
  function automatic logic vec_enable(input logic       master,
                                      input logic       cascaded,
                                      input logic       selected,
                                      input logic       m8086,
                                      input logic [1:0] pulse);
    logic is_call;
    is_call = !m8086 && (pulse == 2'd1);
    if (m8086 && (pulse == 2'd1)) return 1'b0;
    if (master) return cascaded ? is_call : 1'b1;
    return selected && !is_call;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cascade_inta_sequencer_inta_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : inta_edge_detect
// Description : Registers INTA_N and produces one-cycle fall/rise strobes
//               from the registered history (prev = older stage).
// Ports       : clk, rst_n      - clock, async active-low reset
//               inta_n          - CPU acknowledge, already synchronous
//               inta_fall/rise  - one-cycle edge strobes
// Revision    : 1.0 - initial release
// ============================================================================
module inta_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic inta_fall,
  output logic inta_rise
);

  logic inta_d1_q, inta_d1_d;
  logic inta_d2_q, inta_d2_d;

  always_comb begin
    inta_d1_d = inta_n;
    inta_d2_d = inta_d1_q;
  end

  // Reset to the inactive (high) level so release never fakes a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_d1_q <= 1'b1;
      inta_d2_q <= 1'b1;
    end else begin
      inta_d1_q <= inta_d1_d;
      inta_d2_q <= inta_d2_d;
    end
  end

  assign inta_fall = inta_d2_q & ~inta_d1_q;
  assign inta_rise = ~inta_d2_q & inta_d1_q;

endmodule
`default_nettype wire

// File: rtl/cascade_inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cascade_inta_sequencer
// Description : 8259 cascade interrupt-acknowledge sequencer. Master mode
//               drives the slave ID onto CAS for the whole INTA sequence;
//               slave mode decodes CAS and releases its vector only when
//               addressed. Tells the data-bus logic which byte to release.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               spen, sngl, mode_8086, icw3    - configuration
//               ir_sel, ir_valid               - resolver request
//               inta_n, cas_in                 - CPU acknowledge, cascade lines
//               cas_out, cas_oe                - cascade drive
//               freeze, latch_isr, latched_ir  - IRR/ISR control
//               vec_oe, vec_sel, seq_done      - data-bus control, AEOI strobe
// Revision    : 1.0 - initial release
// ============================================================================
module cascade_inta_sequencer
  import cascade_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spen,
  input  logic       sngl,
  input  logic       mode_8086,
  input  logic [7:0] icw3,
  input  logic [2:0] ir_sel,
  input  logic       ir_valid,
  input  logic       inta_n,
  input  logic [2:0] cas_in,
  output logic [2:0] cas_out,
  output logic       cas_oe,
  output logic       freeze,
  output logic       latch_isr,
  output logic [2:0] latched_ir,
  output logic       vec_oe,
  output logic [1:0] vec_sel,
  output logic       seq_done
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic inta_fall, inta_rise;

  inta_edge_detect u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .inta_n    (inta_n),
    .inta_fall (inta_fall),
    .inta_rise (inta_rise)
  );

  state_e     state_q, state_d;
  logic [1:0] pulse_q, pulse_d;
  logic [7:0] tmo_q, tmo_d;
  logic       mode_q, mode_d;          // 1 = master for this sequence
  logic       m8086_q, m8086_d;
  logic       sngl_q, sngl_d;
  logic [2:0] own_id_q, own_id_d;
  logic       ir_valid_q, ir_valid_d;
  logic       cascaded_q, cascaded_d;
  logic       selected_q, selected_d;
  logic [2:0] cas_out_q, cas_out_d;
  logic       cas_oe_q, cas_oe_d;
  logic       freeze_q, freeze_d;
  logic       latch_isr_q, latch_isr_d;
  logic [2:0] latched_ir_q, latched_ir_d;
  logic       vec_oe_q, vec_oe_d;
  logic [1:0] vec_sel_q, vec_sel_d;
  logic       seq_done_q, seq_done_d;

  logic       casc_first;
  logic       sel_first;
  logic [1:0] last_pulse;
  logic [1:0] pulse_next;

  // Cascade decision uses live inputs because it is taken on the first fall.
  assign casc_first = spen & ~sngl & ir_valid & icw3[ir_sel];
  // Slave decision uses the configuration latched at the first fall.
  assign sel_first  = ~sngl_q & (cas_in == own_id_q);
  assign last_pulse = m8086_q ? PULSES_8086 : PULSES_8085;
  assign pulse_next = pulse_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    pulse_d      = pulse_q;
    tmo_d        = tmo_q;
    mode_d       = mode_q;
    m8086_d      = m8086_q;
    sngl_d       = sngl_q;
    own_id_d     = own_id_q;
    ir_valid_d   = ir_valid_q;
    cascaded_d   = cascaded_q;
    selected_d   = selected_q;
    cas_out_d    = cas_out_q;
    cas_oe_d     = cas_oe_q;
    freeze_d     = freeze_q;
    latched_ir_d = latched_ir_q;
    vec_oe_d     = vec_oe_q;
    vec_sel_d    = vec_sel_q;
    latch_isr_d  = 1'b0;
    seq_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (inta_fall) begin
          state_d      = ST_PULSE;
          pulse_d      = 2'd1;
          tmo_d        = 8'd0;
          mode_d       = spen;
          m8086_d      = mode_8086;
          sngl_d       = sngl;
          own_id_d     = icw3[2:0];
          ir_valid_d   = ir_valid;
          selected_d   = 1'b0;
          freeze_d     = 1'b1;
          latched_ir_d = ir_valid ? ir_sel : 3'd7;
          cascaded_d   = casc_first;
          cas_oe_d     = casc_first;
          cas_out_d    = casc_first ? ir_sel : 3'd0;
          latch_isr_d  = spen & ir_valid;
          vec_oe_d     = vec_enable(spen, casc_first, 1'b0, mode_8086, 2'd1);
          vec_sel_d    = vsel_for(mode_8086, 2'd1);
        end
      end
      ST_PULSE: begin
        if (inta_rise) begin
          vec_oe_d = 1'b0;
          if (!mode_q && (pulse_q == 2'd1)) begin
            selected_d  = sel_first;
            latch_isr_d = sel_first & ir_valid_q;
          end
          if (pulse_q == last_pulse) begin
            state_d    = ST_DONE;
            seq_done_d = 1'b1;
            freeze_d   = 1'b0;
          end else begin
            state_d = ST_GAP;
            tmo_d   = 8'd0;
          end
        end
      end
      ST_GAP: begin
        if (inta_fall) begin
          state_d   = ST_PULSE;
          pulse_d   = pulse_next;
          vec_oe_d  = vec_enable(mode_q, cascaded_q, selected_q, m8086_q, pulse_next);
          vec_sel_d = vsel_for(m8086_q, pulse_next);
        end else if (tmo_q == TMO_LAST) begin
          // Abort: release everything silently, no SEQ_DONE.
          state_d   = ST_IDLE;
          tmo_d     = 8'd0;
          freeze_d  = 1'b0;
          cas_oe_d  = 1'b0;
          cas_out_d = 3'd0;
          vec_oe_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_DONE: begin
        // Falls seen here are dropped; a new sequence must start from IDLE.
        state_d   = ST_IDLE;
        cas_oe_d  = 1'b0;
        cas_out_d = 3'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pulse_q      <= 2'd0;
      tmo_q        <= 8'd0;
      mode_q       <= 1'b0;
      m8086_q      <= 1'b0;
      sngl_q       <= 1'b0;
      own_id_q     <= 3'd0;
      ir_valid_q   <= 1'b0;
      cascaded_q   <= 1'b0;
      selected_q   <= 1'b0;
      cas_out_q    <= 3'd0;
      cas_oe_q     <= 1'b0;
      freeze_q     <= 1'b0;
      latch_isr_q  <= 1'b0;
      latched_ir_q <= 3'd0;
      vec_oe_q     <= 1'b0;
      vec_sel_q    <= 2'd0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      tmo_q        <= tmo_d;
      mode_q       <= mode_d;
      m8086_q      <= m8086_d;
      sngl_q       <= sngl_d;
      own_id_q     <= own_id_d;
      ir_valid_q   <= ir_valid_d;
      cascaded_q   <= cascaded_d;
      selected_q   <= selected_d;
      cas_out_q    <= cas_out_d;
      cas_oe_q     <= cas_oe_d;
      freeze_q     <= freeze_d;
      latch_isr_q  <= latch_isr_d;
      latched_ir_q <= latched_ir_d;
      vec_oe_q     <= vec_oe_d;
      vec_sel_q    <= vec_sel_d;
      seq_done_q   <= seq_done_d;
    end
  end

  assign cas_out    = cas_out_q;
  assign cas_oe     = cas_oe_q;
  assign freeze     = freeze_q;
  assign latch_isr  = latch_isr_q;
  assign latched_ir = latched_ir_q;
  assign vec_oe     = vec_oe_q;
  assign vec_sel    = vec_sel_q;
  assign seq_done   = seq_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cascade_inta_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cascade_inta_sequencer
// Description : Scoreboard bench for cascade_inta_sequencer. Each INTA
//               sequence is planned by a reference model that pushes the
//               expected LATCH_ISR / VEC_OE / SEQ_DONE events into a queue;
//               an independent monitor pops and compares as the DUT emits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cascade_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spen, sngl, mode_8086, ir_valid, inta_n;
  logic [7:0] icw3;
  logic [2:0] ir_sel, cas_in;
  logic [2:0] cas_out, latched_ir;
  logic       cas_oe, freeze, latch_isr, vec_oe, seq_done;
  logic [1:0] vec_sel;

  always #5 clk = ~clk;

  cascade_inta_sequencer #(.TIMEOUT_CYCLES(255)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spen       (spen),
    .sngl       (sngl),
    .mode_8086  (mode_8086),
    .icw3       (icw3),
    .ir_sel     (ir_sel),
    .ir_valid   (ir_valid),
    .inta_n     (inta_n),
    .cas_in     (cas_in),
    .cas_out    (cas_out),
    .cas_oe     (cas_oe),
    .freeze     (freeze),
    .latch_isr  (latch_isr),
    .latched_ir (latched_ir),
    .vec_oe     (vec_oe),
    .vec_sel    (vec_sel),
    .seq_done   (seq_done)
  );

  localparam int EV_LATCH = 0;
  localparam int EV_VEC   = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t evq[$];
  int  checks = 0;
  int  errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic void push_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    evq.push_back(e);
  endfunction

  function automatic void take(input int kind, input int val);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual_kind=%0d actual_val=%0d expected=none", kind, val);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event actual_kind=%0d actual_val=%0d expected_kind=%0d expected_val=%0d",
                 kind, val, e.kind, e.val);
      end
    end
  endfunction

  // Monitor: decoupled from stimulus, reacts to whatever the DUT presents.
  logic vec_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (latch_isr === 1'b1) take(EV_LATCH, int'(latched_ir));
      if (vec_oe === 1'b1 && vec_prev !== 1'b1) take(EV_VEC, int'(vec_sel));
      if (seq_done === 1'b1) take(EV_DONE, 0);
    end
    vec_prev = vec_oe;
  end

  // run mode: 0 = full sequence, 1 = one pulse then timeout, 2 = reset in pulse 2
  task automatic run_seq(input bit m, input bit m86, input bit sg, input logic [7:0] i3,
                         input logic [2:0] irs, input bit irv, input logic [2:0] cin,
                         input int run_mode);
    int         n, npl, lo, gp;
    logic [2:0] exp_lat;
    bit         casc, sel;
    bit         rel[1:3];
    int         code[1:3];
    bit         has_byte, is_call;

    // Reference plan derived from the acknowledge rules.
    n       = m86 ? 2 : 3;
    exp_lat = irv ? irs : 3'd7;
    casc    = m && !sg && irv && i3[irs];
    sel     = !m && !sg && (cin == i3[2:0]);
    for (int p = 1; p <= 3; p++) begin
      // 8085 bytes: CALL(0), LO(1), HI(2); 8086: pulse 1 empty, pulse 2 LO.
      has_byte = !(m86 && p == 1);
      code[p]  = m86 ? 1 : p - 1;
      is_call  = has_byte && (code[p] == 0);
      if (!has_byte)      rel[p] = 0;
      else if (m && casc) rel[p] = is_call;
      else if (m)         rel[p] = 1;
      else                rel[p] = sel && !is_call;
    end
    npl = (run_mode == 0) ? n : (run_mode == 1 ? 1 : 2);
    for (int p = 1; p <= npl; p++) begin
      if (p == 1 && m && irv) push_ev(EV_LATCH, int'(exp_lat));
      if (rel[p]) push_ev(EV_VEC, code[p]);
      if (p == 1 && !m && sel && irv && !(run_mode == 2 && npl == 1)) push_ev(EV_LATCH, int'(exp_lat));
    end
    if (run_mode == 0) push_ev(EV_DONE, 0);

    @(negedge clk);
    spen = m; mode_8086 = m86; sngl = sg; icw3 = i3;
    ir_sel = irs; ir_valid = irv; cas_in = cin;
    repeat (3) @(negedge clk);

    for (int p = 1; p <= npl; p++) begin
      inta_n = 1'b0;
      lo = $urandom_range(2, 5);
      repeat (lo) @(negedge clk);
      if (p == 1) begin
        // Config changes mid-sequence must not affect the latched values.
        spen      = $urandom_range(0, 1);
        mode_8086 = $urandom_range(0, 1);
        ir_sel    = 3'($urandom_range(0, 7));
      end
      check("vec_oe_in_pulse", vec_oe, rel[p]);
      if (rel[p]) check("vec_sel_in_pulse", vec_sel, code[p]);
      check("freeze_in_seq", freeze, 1);
      check("latched_ir", latched_ir, exp_lat);
      check("cas_oe_in_seq", cas_oe, casc);
      check("cas_out_in_seq", cas_out, casc ? exp_lat : 3'd0);
      if (run_mode == 2 && p == npl) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_cas_oe", cas_oe, 0);
        check("rst_vec_oe", vec_oe, 0);
        check("rst_freeze", freeze, 0);
        check("rst_latched_ir", latched_ir, 0);
        inta_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_events_pending", evq.size(), 0);
        evq.delete();
        repeat (2) @(negedge clk);
        return;
      end
      inta_n = 1'b1;
      gp = $urandom_range(2, 6);
      repeat (gp) @(negedge clk);
      check("vec_oe_after_rise", vec_oe, 0);
    end

    if (run_mode == 1) begin
      repeat (100) @(negedge clk);
      check("freeze_waiting", freeze, 1);
      repeat (160) @(negedge clk);
    end else begin
      repeat (2) @(negedge clk);
    end
    check("cas_oe_after_seq", cas_oe, 0);
    check("freeze_after_seq", freeze, 0);
    check("events_pending", evq.size(), 0);
    evq.delete();
  endtask

  initial begin
    rst_n = 1'b0; inta_n = 1'b1; spen = 1'b0; sngl = 1'b0; mode_8086 = 1'b0;
    icw3 = 8'h00; ir_sel = 3'd0; ir_valid = 1'b0; cas_in = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_cas_oe", cas_oe, 0);
    check("reset_cas_out", cas_out, 0);
    check("reset_freeze", freeze, 0);
    check("reset_latch_isr", latch_isr, 0);
    check("reset_latched_ir", latched_ir, 0);
    check("reset_vec_oe", vec_oe, 0);
    check("reset_vec_sel", vec_sel, 0);
    check("reset_seq_done", seq_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(1, 1, 0, 8'h04, 3'd2, 1, 3'd0, 0);   // master 8086 cascaded
    run_seq(1, 0, 0, 8'h00, 3'd5, 1, 3'd0, 0);   // master 8085 flat
    run_seq(0, 1, 0, 8'h03, 3'd6, 1, 3'd3, 0);   // slave addressed
    run_seq(0, 1, 0, 8'h03, 3'd6, 1, 3'd4, 0);   // slave not addressed
    run_seq(1, 1, 0, 8'hFF, 3'd1, 0, 3'd0, 0);   // spurious master
    run_seq(0, 0, 0, 8'h05, 3'd2, 1, 3'd5, 0);   // slave 8085 addressed
    run_seq(1, 1, 0, 8'h04, 3'd2, 1, 3'd0, 1);   // timeout abort
    run_seq(1, 1, 0, 8'h04, 3'd2, 1, 3'd0, 0);   // normal after abort
    run_seq(1, 1, 0, 8'h04, 3'd2, 1, 3'd0, 2);   // reset in pulse 2
    run_seq(1, 1, 0, 8'h04, 3'd2, 1, 3'd0, 0);   // normal after reset

    for (int i = 0; i < 40; i++) begin
      logic [7:0] r_i3;
      logic [2:0] r_cin;
      r_i3  = 8'($urandom_range(0, 255));
      r_cin = ($urandom_range(0, 1) == 1) ? r_i3[2:0] : 3'($urandom_range(0, 7));
      run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0), r_i3, 3'($urandom_range(0, 7)),
              ($urandom_range(0, 4) != 0), r_cin, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/cascade_inta_sequencer.md
# cascade_inta_sequencer

Sequential interrupt-acknowledge controller for the cascade interface of the 8259 PIC. In master mode it tracks the CPU INTA pulses, drives the selected slave ID onto the cascade lines for the whole acknowledge sequence and tells the data-bus logic which vector byte to release. In slave mode it samples the cascade lines, decides whether this device is addressed, and enables vector release only when it is. It sits between the priority resolver/ISR logic and the top-level CAS tristate pins.

## Interface
- TIMEOUT_CYCLES, 255: maximum CLK cycles between INTA pulses before the sequence is aborted (1..255).
- CLK  in  1  single system clock.
- RST_N  in  1  asynchronous, active-low reset.
- SPEN  in  1  1 = master, 0 = slave; latched at the first INTA falling edge.
- SNGL  in  1  1 = single-device mode, so cascade is never used.
- MODE_8086  in  1  1 = two-pulse 8086 sequence, 0 = three-pulse 8085 sequence.
- ICW3  in  8  master: bit n = slave on IRn; slave: [2:0] = own slave ID.
- IR_SEL  in  3  highest-priority IR from the resolver.
- IR_VALID  in  1  IR_SEL is a real request.
- INTA_N  in  1  CPU acknowledge, already synchronous to CLK.
- CAS_IN  in  3  sampled cascade lines.
- CAS_OUT  out  3  cascade value to drive.
- CAS_OE  out  1  cascade tristate enable.
- FREEZE  out  1  freezes IRR for the duration of the sequence.
- LATCH_ISR  out  1  one-cycle pulse that sets the ISR bit of LATCHED_IR.
- LATCHED_IR  out  3  IR captured at the first pulse.
- VEC_OE  out  1  this device drives the data bus now.
- VEC_SEL  out  2  0 = CALL opcode, 1 = vector/low byte, 2 = high byte.
- SEQ_DONE  out  1  one-cycle pulse at the end of the last pulse (for AEOI).

## Operation
- INTA_N is registered internally. A fall means prev=1 and now=0; a rise means prev=0 and now=1.
- State machine: IDLE, PULSE, GAP, DONE. A pulse counter (2 bits) tracks the current pulse.
  - IDLE to PULSE on fall (pulse 1). PULSE to GAP on rise when the pulse is not the last one.
  - GAP to PULSE on fall, and the pulse counter increments.
  - PULSE to DONE on rise of the last pulse (2 for 8086, 3 for 8085). DONE to IDLE after one cycle.
  - GAP to IDLE if TIMEOUT_CYCLES elapse without a fall. This is an abort: SEQ_DONE is not pulsed.
- First fall, all modes:
  - latch SPEN into mode_q and assert FREEZE;
  - if IR_VALID=1: LATCHED_IR = IR_SEL;
  - if IR_VALID=0 (spurious): LATCHED_IR = 7.
- Master, first fall:
  - LATCH_ISR pulses only if IR_VALID=1.
  - The sequence is cascaded if SNGL=0, IR_VALID=1 and ICW3[IR_SEL]=1.
  - When cascaded: CAS_OE=1 and CAS_OUT=LATCHED_IR, held until DONE.
- Slave, first rise: selected = (SNGL=0 and CAS_IN == ICW3[2:0]). LATCH_ISR pulses if selected=1 and IR_VALID=1.
- VEC_OE is asserted only while INTA_N=0, with VEC_SEL = 0/1/2 for pulse 1/2/3 (8085), or VEC_SEL = 1 on pulse 2 (8086):
  - master, not cascaded: every data pulse;
  - master, cascaded: 8085 pulse 1 (CALL) only;
  - slave, selected: every data pulse except the CALL;
  - slave, not selected: never.
- 8086 pulse 1 never asserts VEC_OE.
- A fall while in DONE is ignored. A new sequence needs IDLE.

## Timing
- Outputs are registered. An edge sampled at CLK edge N produces its output change after edge N+1.
- CAS_OE/CAS_OUT are valid from cycle N+1 after the first fall and deassert the cycle after DONE, or on abort.
- The slave's decision needs CAS stable at the first rise, so CAS_IN must be valid at least 2 CLK cycles before it.
- VEC_OE drops in the cycle after a rise.
- SEQ_DONE pulses and FREEZE falls in the DONE cycle.
- Reset (asynchronous, at any time, including mid-sequence):
  - state = IDLE;
  - all outputs 0, including CAS_OE=0 and LATCHED_IR=0;
  - timeout counter = 0.
- The CONFIG inputs (SPEN, ICW3, MODE_8086, SNGL) are ignored mid-sequence except where they are latched.

## Structure
- Package cascade_pkg:
  - state enum;
  - VEC_SEL codes (VSEL_CALL, VSEL_LO, VSEL_HI);
  - CALL_OPCODE = 8'hCD;
  - pulse counts (PULSES_8086 = 2, PULSES_8085 = 3).
- One sub-module, inta_edge_detect: registered INTA_N with fall/rise pulses.
- The timeout counter stays inline.

## Test plan
- Master, 8086, ICW3=8'h04, IR_SEL=2 valid, two INTA pulses:
  - CAS_OE=1, CAS_OUT=3'd2 from cycle after the first fall until after DONE;
  - LATCH_ISR once, VEC_OE never, SEQ_DONE once.
- Master, 8085, ICW3=0, IR_SEL=5:
  - VEC_OE on all three pulses with VEC_SEL 0, 1, 2;
  - CAS_OE stays 0.
- Slave ID 3, 8086, CAS_IN=3 before the first rise: VEC_OE with VEC_SEL=1 on pulse 2 only. Repeat with CAS_IN=4: VEC_OE never asserted, LATCH_ISR never pulsed.
- Spurious (IR_VALID=0), master: LATCHED_IR=7, no LATCH_ISR, no cascade, vector still released on pulse 2.
- After one pulse, wait 256 cycles with no second pulse: abort to IDLE, CAS_OE=0, FREEZE=0, no SEQ_DONE.
- RST_N low during pulse 2 of a cascaded sequence: CAS_OE, VEC_OE and FREEZE go 0 immediately. A later full sequence behaves normally.
